// File: rtl/mux_scan_nto1_pkg.sv
// rtl/mux_scan_nto1_pkg.sv - shared types and width helper for the N:1 scan selector
package mux_scan_pkg;

  // Controller states: idle, holding a manual word, auto-scanning
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  // Index width for n items; never below one bit so degenerate counts stay legal
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_nto1_if.sv
// rtl/mux_scan_nto1_if.sv - channel bus, control and output handshake bundle
interface mux_scan_nto1_if
  import mux_scan_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 1
);

  localparam int SELW = sel_width(N);

  logic [N*W-1:0]  din;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            start;
  logic            stop;
  logic [W-1:0]    out;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] cur_sel;
  logic            busy;
  logic            err;

  // Driver of channels, requests and the consumer side
  modport master (
    output din, sel, mode, start, stop, out_ready,
    input  out, out_valid, cur_sel, busy, err
  );

  // The selector itself
  modport slave (
    input  din, sel, mode, start, stop, out_ready,
    output out, out_valid, cur_sel, busy, err
  );

endinterface

// File: rtl/mux_scan_nto1_mux.sv
// rtl/mux_scan_nto1_mux.sv - combinational N:1 slice selector, out-of-range index gives zero
module mux_nto1 #(
  parameter int N  = 16,
  parameter int W  = 1,
  parameter int IW = 4
) (
  input  logic [N*W-1:0] din_i,
  input  logic [IW-1:0]  idx_i,
  output logic [W-1:0]   y_o
);

  // Priority-free one-hot style select; indices N..2^IW-1 fall through to zero
  always_comb begin
    y_o = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(idx_i) == i) begin
        y_o = din_i[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// rtl/mux_scan_nto1.sv - N:1 channel selector with manual capture and round-robin scan
module mux_scan_nto1
  import mux_scan_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_scan_nto1_if.slave    bus
);

  localparam int SELW = sel_width(N);
  localparam int CNTW = sel_width(DWELL);

  state_e          state_q, state_d;
  logic [W-1:0]    out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [SELW-1:0] mux_idx;
  logic [W-1:0]    mux_y;
  logic            xfer;
  logic            sel_oob;
  logic            dwell_done;
  logic            can_capture;

  // In IDLE the request select drives the mux; otherwise the scan pointer does
  assign mux_idx     = (state_q == IDLE) ? bus.sel : cur_sel_q;
  assign xfer        = out_valid_q & bus.out_ready;
  assign sel_oob     = int'(bus.sel) >= N;
  assign dwell_done  = int'(cnt_q) == (DWELL - 1);
  assign can_capture = !out_valid_q || bus.out_ready;

  mux_nto1 #(
    .N  (N),
    .W  (W),
    .IW (SELW)
  ) u_mux (
    .din_i (bus.din),
    .idx_i (mux_idx),
    .y_o   (mux_y)
  );

  // Next-state logic: FSM transitions, dwell counting, capture and handshake
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cur_sel_d   = cur_sel_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;

    // A consumed word drops valid unless a capture below refills it this cycle
    if (xfer) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) begin
          if (sel_oob) begin
            err_d = 1'b1;
          end else if (!bus.mode) begin
            out_d       = mux_y;
            out_valid_d = 1'b1;
            cur_sel_d   = bus.sel;
            state_d     = HOLD;
          end else begin
            cur_sel_d = bus.sel;
            cnt_d     = '0;
            state_d   = SCAN;
          end
        end
      end

      HOLD: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end

      SCAN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (dwell_done) begin
          // Stall with counter and pointer frozen while an unconsumed word blocks
          if (can_capture) begin
            out_d       = mux_y;
            out_valid_d = 1'b1;
            cur_sel_d   = (int'(cur_sel_q) == N - 1) ? '0 : cur_sel_q + 1'b1;
            cnt_d       = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset that discards any pending word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cur_sel_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_sel_q   <= cur_sel_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb/tb_mux_scan_nto1.sv - directed self-checking bench for mux_scan_nto1
module tb_mux_scan_nto1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mux_scan_nto1_if #(.N(16), .W(1)) b16 ();
  mux_scan_nto1_if #(.N(12), .W(1)) b12 ();

  mux_scan_nto1 #(.N(16), .W(1), .DWELL(2)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  mux_scan_nto1 #(.N(12), .W(1), .DWELL(2)) u12 (
    .clk (clk),
    .rst (rst),
    .bus (b12.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start16(input logic [3:0] s, input logic m);
    b16.sel   = s;
    b16.mode  = m;
    b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (b16.out !== 1'b0) begin failures++; $display("FAIL reset_out got=%0b exp=0", b16.out); end
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", b16.out_valid); end
    checks++; if (b16.cur_sel !== 4'd0) begin failures++; $display("FAIL reset_cur_sel got=%0d exp=0", b16.cur_sel); end
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", b16.busy); end
    checks++; if (b16.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", b16.err); end
    checks++; if (b12.busy !== 1'b0) begin failures++; $display("FAIL reset_busy12 got=%0b exp=0", b12.busy); end
  endtask

  task automatic test_manual;
    b16.out_ready = 1'b1;
    start16(4'd3, 1'b0);
    checks++; if (b16.out !== 1'b1) begin failures++; $display("FAIL man3_out got=%0b exp=1", b16.out); end
    checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL man3_valid got=%0b exp=1", b16.out_valid); end
    checks++; if (b16.busy !== 1'b1) begin failures++; $display("FAIL man3_busy got=%0b exp=1", b16.busy); end
    checks++; if (b16.cur_sel !== 4'd3) begin failures++; $display("FAIL man3_cur_sel got=%0d exp=3", b16.cur_sel); end
    @(negedge clk);
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL man3_drain got=%0b exp=0", b16.out_valid); end
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL man3_idle got=%0b exp=0", b16.busy); end
    start16(4'd4, 1'b0);
    checks++; if (b16.out !== 1'b0) begin failures++; $display("FAIL man4_out got=%0b exp=0", b16.out); end
    checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL man4_valid got=%0b exp=1", b16.out_valid); end
    @(negedge clk);
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL man4_idle got=%0b exp=0", b16.busy); end
  endtask

  task automatic test_scan_seq;
    logic [15:0] pat;
    pat = 16'h3f0a;
    b16.out_ready = 1'b1;
    start16(4'd0, 1'b1);
    checks++; if (b16.busy !== 1'b1) begin failures++; $display("FAIL scan_busy got=%0b exp=1", b16.busy); end
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL scan_first_valid got=%0b exp=0", b16.out_valid); end
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      @(negedge clk);
      checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL scan_valid k=%0d got=%0b exp=1", k, b16.out_valid); end
      checks++; if (b16.out !== pat[k % 16]) begin failures++; $display("FAIL scan_out k=%0d got=%0b exp=%0b", k, b16.out, pat[k % 16]); end
      checks++; if (b16.cur_sel !== 4'((k + 1) % 16)) begin failures++; $display("FAIL scan_cur_sel k=%0d got=%0d exp=%0d", k, b16.cur_sel, (k + 1) % 16); end
    end
    b16.stop = 1'b1;
    @(negedge clk);
    b16.stop = 1'b0;
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL scan_stop_busy got=%0b exp=0", b16.busy); end
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL scan_stop_valid got=%0b exp=0", b16.out_valid); end
  endtask

  task automatic test_backpressure;
    b16.out_ready = 1'b0;
    start16(4'd7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (b16.out !== 1'b0) begin failures++; $display("FAIL bp_first_out got=%0b exp=0", b16.out); end
    checks++; if (b16.cur_sel !== 4'd8) begin failures++; $display("FAIL bp_first_sel got=%0d exp=8", b16.cur_sel); end
    repeat (10) @(negedge clk);
    checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%0b exp=1", b16.out_valid); end
    checks++; if (b16.out !== 1'b0) begin failures++; $display("FAIL bp_hold_out got=%0b exp=0", b16.out); end
    checks++; if (b16.cur_sel !== 4'd8) begin failures++; $display("FAIL bp_hold_sel got=%0d exp=8", b16.cur_sel); end
    b16.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL bp_resume_valid got=%0b exp=1", b16.out_valid); end
    checks++; if (b16.out !== 1'b1) begin failures++; $display("FAIL bp_resume_out got=%0b exp=1", b16.out); end
    checks++; if (b16.cur_sel !== 4'd9) begin failures++; $display("FAIL bp_resume_sel got=%0d exp=9", b16.cur_sel); end
    @(negedge clk);
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL bp_gap_valid got=%0b exp=0", b16.out_valid); end
    @(negedge clk);
    checks++; if (b16.cur_sel !== 4'd10) begin failures++; $display("FAIL bp_next_sel got=%0d exp=10", b16.cur_sel); end
    checks++; if (b16.out !== 1'b1) begin failures++; $display("FAIL bp_next_out got=%0b exp=1", b16.out); end
    b16.stop = 1'b1;
    @(negedge clk);
    b16.stop = 1'b0;
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL bp_stop_busy got=%0b exp=0", b16.busy); end
  endtask

  task automatic test_stop;
    b16.out_ready = 1'b1;
    b16.stop = 1'b1;
    start16(4'd0, 1'b1);
    b16.stop = 1'b0;
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL stop_start_busy got=%0b exp=0", b16.busy); end
    checks++; if (b16.err !== 1'b0) begin failures++; $display("FAIL stop_start_err got=%0b exp=0", b16.err); end
    b16.out_ready = 1'b0;
    start16(4'd8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (b16.out !== 1'b1) begin failures++; $display("FAIL stop_pend_out got=%0b exp=1", b16.out); end
    start16(4'd2, 1'b0);
    checks++; if (b16.err !== 1'b0) begin failures++; $display("FAIL busy_start_err got=%0b exp=0", b16.err); end
    checks++; if (b16.cur_sel !== 4'd9) begin failures++; $display("FAIL busy_start_sel got=%0d exp=9", b16.cur_sel); end
    b16.stop = 1'b1;
    @(negedge clk);
    b16.stop = 1'b0;
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL stop_mid_busy got=%0b exp=0", b16.busy); end
    checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL stop_mid_valid got=%0b exp=1", b16.out_valid); end
    repeat (3) @(negedge clk);
    checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL stop_keep_valid got=%0b exp=1", b16.out_valid); end
    checks++; if (b16.out !== 1'b1) begin failures++; $display("FAIL stop_keep_out got=%0b exp=1", b16.out); end
    checks++; if (b16.cur_sel !== 4'd9) begin failures++; $display("FAIL stop_keep_sel got=%0d exp=9", b16.cur_sel); end
    b16.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL stop_xfer_valid got=%0b exp=0", b16.out_valid); end
    @(negedge clk);
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL stop_once_valid got=%0b exp=0", b16.out_valid); end
  endtask

  task automatic test_n12;
    b12.out_ready = 1'b1;
    b12.sel   = 4'd13;
    b12.mode  = 1'b1;
    b12.start = 1'b1;
    @(negedge clk);
    b12.start = 1'b0;
    checks++; if (b12.err !== 1'b1) begin failures++; $display("FAIL n12_err got=%0b exp=1", b12.err); end
    checks++; if (b12.busy !== 1'b0) begin failures++; $display("FAIL n12_err_busy got=%0b exp=0", b12.busy); end
    @(negedge clk);
    checks++; if (b12.err !== 1'b0) begin failures++; $display("FAIL n12_err_pulse got=%0b exp=0", b12.err); end
    b12.sel   = 4'd10;
    b12.start = 1'b1;
    @(negedge clk);
    b12.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (b12.out !== 1'b0) begin failures++; $display("FAIL n12_ch10 got=%0b exp=0", b12.out); end
    checks++; if (b12.cur_sel !== 4'd11) begin failures++; $display("FAIL n12_sel11 got=%0d exp=11", b12.cur_sel); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (b12.out !== 1'b1) begin failures++; $display("FAIL n12_ch11 got=%0b exp=1", b12.out); end
    checks++; if (b12.cur_sel !== 4'd0) begin failures++; $display("FAIL n12_wrap got=%0d exp=0", b12.cur_sel); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (b12.out !== 1'b0) begin failures++; $display("FAIL n12_ch0 got=%0b exp=0", b12.out); end
    checks++; if (b12.cur_sel !== 4'd1) begin failures++; $display("FAIL n12_sel1 got=%0d exp=1", b12.cur_sel); end
    b12.stop = 1'b1;
    @(negedge clk);
    b12.stop = 1'b0;
    checks++; if (b12.busy !== 1'b0) begin failures++; $display("FAIL n12_stop got=%0b exp=0", b12.busy); end
  endtask

  task automatic test_reset_mid_scan;
    b16.out_ready = 1'b0;
    start16(4'd8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (b16.out_valid !== 1'b1) begin failures++; $display("FAIL rms_pre_valid got=%0b exp=1", b16.out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b16.out !== 1'b0) begin failures++; $display("FAIL rms_out got=%0b exp=0", b16.out); end
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL rms_valid got=%0b exp=0", b16.out_valid); end
    checks++; if (b16.cur_sel !== 4'd0) begin failures++; $display("FAIL rms_cur_sel got=%0d exp=0", b16.cur_sel); end
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL rms_busy got=%0b exp=0", b16.busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b16.busy !== 1'b0) begin failures++; $display("FAIL rms_after_busy got=%0b exp=0", b16.busy); end
    checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL rms_after_valid got=%0b exp=0", b16.out_valid); end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    b16.din       = 16'h3f0a;
    b16.sel       = '0;
    b16.mode      = 1'b0;
    b16.start     = 1'b0;
    b16.stop      = 1'b0;
    b16.out_ready = 1'b0;
    b12.din       = 12'ha5c;
    b12.sel       = '0;
    b12.mode      = 1'b0;
    b12.start     = 1'b0;
    b12.stop      = 1'b0;
    b12.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_manual;
    test_scan_seq;
    test_backpressure;
    test_stop;
    test_n12;
    test_reset_mid_scan;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
